interface_botoes_jogada: RTL and testbench
==========================================

Name: interface_botoes_jogada

Overview:
- Upstream input conditioner for the memory-game datapath/control pair.
- Takes raw, asynchronous push-button signals: four play buttons and one start button.
- Per signal: synchronizes, debounces, and turns each accepted press into a single-cycle event.
- Delivers a registered one-hot `chaves` value with a `jogada_feita` strobe, and a clean one-cycle `iniciar` pulse, to the game circuit.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples required to accept a level change. Legal range ≥1; benches use 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of the debounce counters. Derived; never overridden.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- botoes  in  4  raw play buttons, asynchronous, active-high
- iniciar_bruto  in  1  raw start button, asynchronous, active-high
- chaves  out  4  last accepted one-hot play, registered, held until next accepted play
- jogada_feita  out  1  one-cycle pulse; `chaves` valid in the same cycle
- erro_multiplo  out  1  one-cycle pulse when a debounced press is not one-hot
- iniciar  out  1  one-cycle pulse per debounced start press
- db_estado  out  4  play FSM state code, feeds hexa7seg

Behaviour:
- Synchronization:
  - Two-flop synchronizer on each of the 5 raw inputs.
  - Reset loads the inactive level (0 after any inversion).
- Play FSM states and codes: OCIOSO=0, FILTRANDO=1, VALIDA=2, ESPERA_SOLTAR=3. Register `amostra[3:0]`, counter `cnt`.
- OCIOSO:
  - If botoes_sync≠0: amostra<=botoes_sync, cnt<=0, go FILTRANDO.
- FILTRANDO:
  - botoes_sync==0: go OCIOSO.
  - botoes_sync≠amostra (nonzero): amostra<=botoes_sync, cnt<=0, stay.
  - Else if cnt==DEBOUNCE_CYCLES-1: go VALIDA; on this same edge chaves<=amostra, only if amostra is one-hot.
  - Else cnt<=cnt+1.
- VALIDA (exactly one cycle):
  - jogada_feita = amostra one-hot.
  - erro_multiplo = !one-hot.
  - Always go ESPERA_SOLTAR, cnt<=0.
- ESPERA_SOLTAR:
  - botoes_sync≠0: cnt<=0.
  - botoes_sync==0 and cnt==DEBOUNCE_CYCLES-1: go OCIOSO.
  - Else cnt<=cnt+1.
  - Holding a button never produces a second event.
- Latency: raw press first sampled at edge E0 and stable thereafter → jogada_feita high in the cycle after edge E0+DEBOUNCE_CYCLES+2.
- Bounce during FILTRANDO restarts the filter; at most one event per press/release cycle.
- chaves resets to 0000. It is never cleared by release; it is only overwritten by a valid one-hot play.
- Start path:
  - Independent counter filter drives a level `iniciar_filt`.
  - When iniciar_sync≠iniciar_filt for DEBOUNCE_CYCLES consecutive cycles, iniciar_filt toggles; any agreeing sample clears the counter.
  - iniciar = iniciar_filt & ~iniciar_filt_d (registered rising edge); one pulse per press.
  - Start and play paths are fully independent; simultaneous events are both reported.
- Reset, including mid-FILTRANDO/ESPERA_SOLTAR:
  - Next cycle: OCIOSO, all counters 0, chaves=0000.
  - All pulse outputs 0; iniciar_filt=0; db_estado=0.
- Outputs are glitch-free: pulses decoded from registered state only.

Optional Feature:
- BOTOES_ATIVO_BAIXO_EN defined: botoes and iniciar_bruto are inverted before the synchronizers (active-low board push-buttons). Synchronizers reset to 1 at the raw side, so a released button reads 0 internally.
- Undefined: inputs are active-high and used directly.
- All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset asserted 2 cycles, inputs 0 → chaves=0000, jogada_feita=erro_multiplo=iniciar=0, db_estado=0.
- botoes=0100 held 20 cycles, first sampled at E0 → exactly one jogada_feita pulse at E0+6 with chaves=0100; chaves stays 0100 after release.
- botoes toggles 0100/0000 every 2 cycles for 12 cycles, then 0100 stable → exactly one jogada_feita; no pulse during bouncing.
- After a 0100 play, botoes=0101 held → one erro_multiplo pulse, no jogada_feita, chaves remains 0100.
- 0010 held 100 cycles → single pulse. Released 3 cycles then re-pressed → no new pulse. Released ≥6 cycles then re-pressed → second pulse with chaves=0010.
- iniciar_bruto high 2 cycles → no iniciar. High 10 cycles → exactly one iniciar pulse. Reset during FILTRANDO → db_estado=0 next cycle, no pulse emitted.

Source files
------------

// File: rtl/interface_botoes_jogada.sv
// Button front end for the memory game: synchronizes, debounces and converts presses into single-cycle events.
// Define BOTOES_ATIVO_BAIXO_EN for active-low board buttons (inputs inverted before synchronizing).
module interface_botoes_jogada #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       iniciar_bruto,
   output logic [3:0] chaves,
   output logic       jogada_feita,
   output logic       erro_multiplo,
   output logic       iniciar,
   output logic [3:0] db_estado
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      OCIOSO        = 2'd0,
      FILTRANDO     = 2'd1,
      VALIDA        = 2'd2,
      ESPERA_SOLTAR = 2'd3
   } estado_t;

   logic [4:0] entrada;
   logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
   estado_t    estado_q, estado_d;
   logic [3:0] amostra_q, amostra_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0] chaves_q, chaves_d;
   logic [CNT_W-1:0] ini_cnt_q, ini_cnt_d;
   logic       ini_filt_q, ini_filt_d;
   logic       ini_filt_dly_q, ini_filt_dly_d;
   logic [3:0] botoes_sync;
   logic       iniciar_sync;
   logic       um_quente;

`ifdef BOTOES_ATIVO_BAIXO_EN
   assign entrada = ~{iniciar_bruto, botoes};
`else
   assign entrada = {iniciar_bruto, botoes};
`endif

   assign botoes_sync  = sync2_q[3:0];
   assign iniciar_sync = sync2_q[4];
   assign um_quente    = (amostra_q != 4'd0) && ((amostra_q & (amostra_q - 4'd1)) == 4'd0);

   always_comb begin
      sync1_d = entrada;
      sync2_d = sync1_q;
   end

   always_comb begin
      estado_d  = estado_q;
      amostra_d = amostra_q;
      cnt_d     = cnt_q;
      chaves_d  = chaves_q;
      case (estado_q)
         OCIOSO: begin
            if (botoes_sync != 4'd0) begin
               amostra_d = botoes_sync;
               cnt_d     = '0;
               estado_d  = FILTRANDO;
            end
         end
         FILTRANDO: begin
            if (botoes_sync == 4'd0) begin
               estado_d = OCIOSO;
            end else if (botoes_sync != amostra_q) begin
               // a bounce to another pattern restarts the filter on the new pattern
               amostra_d = botoes_sync;
               cnt_d     = '0;
            end else if (cnt_q == CNT_MAX) begin
               estado_d = VALIDA;
               if (um_quente) chaves_d = amostra_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         VALIDA: begin
            estado_d = ESPERA_SOLTAR;
            cnt_d    = '0;
         end
         ESPERA_SOLTAR: begin
            if (botoes_sync != 4'd0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               estado_d = OCIOSO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_comb begin
      ini_cnt_d      = '0;
      ini_filt_d     = ini_filt_q;
      ini_filt_dly_d = ini_filt_q;
      if (iniciar_sync != ini_filt_q) begin
         if (ini_cnt_q == CNT_MAX) begin
            ini_filt_d = ~ini_filt_q;
         end else begin
            ini_cnt_d = ini_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         estado_q       <= OCIOSO;
         amostra_q      <= '0;
         cnt_q          <= '0;
         chaves_q       <= '0;
         ini_cnt_q      <= '0;
         ini_filt_q     <= 1'b0;
         ini_filt_dly_q <= 1'b0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         estado_q       <= estado_d;
         amostra_q      <= amostra_d;
         cnt_q          <= cnt_d;
         chaves_q       <= chaves_d;
         ini_cnt_q      <= ini_cnt_d;
         ini_filt_q     <= ini_filt_d;
         ini_filt_dly_q <= ini_filt_dly_d;
      end
   end

   assign chaves        = chaves_q;
   assign jogada_feita  = (estado_q == VALIDA) && um_quente;
   assign erro_multiplo = (estado_q == VALIDA) && !um_quente;
   assign iniciar       = ini_filt_q & ~ini_filt_dly_q;
   assign db_estado     = {2'b00, estado_q};

endmodule

// File: tb/tb_interface_botoes_jogada.sv
// Bench for interface_botoes_jogada: directed segment table plus random segments, all cycles checked against a run-length model.
module tb_interface_botoes_jogada;

   localparam int DEB = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] botoes;
   logic       iniciar_bruto;
   logic [3:0] chaves;
   logic       jogada_feita;
   logic       erro_multiplo;
   logic       iniciar;
   logic [3:0] db_estado;

   interface_botoes_jogada #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clock(clock),
      .reset(reset),
      .botoes(botoes),
      .iniciar_bruto(iniciar_bruto),
      .chaves(chaves),
      .jogada_feita(jogada_feita),
      .erro_multiplo(erro_multiplo),
      .iniciar(iniciar),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // model: raw samples reach the play/start logic two edges late
   logic [4:0] hist[$];
   bit         armed, skip;
   int         run_len, zero_run, ini_run;
   logic [3:0] run_val, m_chaves;
   logic       m_jog, m_err, m_ini, ini_lvl;
   logic [3:0] m_state;

   int seg_jog, seg_err, seg_ini;

   task automatic model_reset();
      hist.delete();
      hist.push_back(5'd0);
      hist.push_back(5'd0);
      armed = 1; skip = 0; run_len = 0; zero_run = 0; run_val = 4'd0;
      m_chaves = 4'd0; ini_lvl = 1'b0; ini_run = 0;
      m_jog = 0; m_err = 0; m_ini = 0;
   endtask

   task automatic model_edge(input logic rst, input logic [3:0] b, input logic ib);
      logic [4:0] s;
      m_jog = 0; m_err = 0; m_ini = 0;
      if (rst) begin
         model_reset();
      end else begin
         hist.push_back({ib, b});
         s = hist.pop_front();
         if (skip) begin
            skip = 0;
            zero_run = 0;
         end else if (!armed) begin
            if (s[3:0] == 4'd0) zero_run++;
            else zero_run = 0;
            if (zero_run == DEB) begin
               armed = 1;
               run_len = 0;
            end
         end else begin
            if (s[3:0] == 4'd0) run_len = 0;
            else if (run_len > 0 && s[3:0] == run_val) run_len++;
            else begin
               run_val = s[3:0];
               run_len = 1;
            end
            if (run_len == DEB + 1) begin
               if ($countones(run_val) == 1) begin
                  m_jog = 1;
                  m_chaves = run_val;
               end else begin
                  m_err = 1;
               end
               armed = 0; skip = 1; zero_run = 0; run_len = 0;
            end
         end
         if (s[4] != ini_lvl) begin
            ini_run++;
            if (ini_run == DEB) begin
               ini_lvl = ~ini_lvl;
               ini_run = 0;
               m_ini = ini_lvl;
            end
         end else begin
            ini_run = 0;
         end
      end
      if (skip) m_state = 4'd2;
      else if (!armed) m_state = 4'd3;
      else if (run_len > 0) m_state = 4'd1;
      else m_state = 4'd0;
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge(reset, botoes, iniciar_bruto);
      @(negedge clock);
      n_vec++;
      if ({chaves, jogada_feita, erro_multiplo, iniciar, db_estado} !==
          {m_chaves, m_jog, m_err, m_ini, m_state}) begin
         n_err++;
         $display("FAIL cycle t=%0t got chaves=%b jog=%b err=%b ini=%b est=%0d, want chaves=%b jog=%b err=%b ini=%b est=%0d",
                  $time, chaves, jogada_feita, erro_multiplo, iniciar, db_estado,
                  m_chaves, m_jog, m_err, m_ini, m_state);
      end
      seg_jog += int'(jogada_feita);
      seg_err += int'(erro_multiplo);
      seg_ini += int'(iniciar);
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] b;
      logic       ib;
      int         n;
      int         jog;
      int         err;
      int         ini;
      logic [3:0] ch;
      int         st;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic [3:0] b, input logic ib, input int n,
                      input int jog, input int err, input int ini, input logic [3:0] ch, input int st);
      vec_t v;
      v.rst = rst; v.b = b; v.ib = ib; v.n = n;
      v.jog = jog; v.err = err; v.ini = ini; v.ch = ch; v.st = st;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b1;
      botoes = 4'd0;
      iniciar_bruto = 1'b0;
      model_reset();

      // rst, botoes, ini, cycles, #jog, #err, #ini, chaves at end, state at end (-1 = any)
      add(1, 4'b0000, 0, 2,   0, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 8,   0, 0, 0, 4'b0000, 0);
      add(0, 4'b0100, 0, 20,  1, 0, 0, 4'b0100, 3);
      add(0, 4'b0000, 0, 10,  0, 0, 0, 4'b0100, 0);
      for (int k = 0; k < 6; k++)
         add(0, (k % 2 == 0) ? 4'b0100 : 4'b0000, 0, 2, 0, 0, 0, 4'b0100, -1);
      add(0, 4'b0100, 0, 20,  1, 0, 0, 4'b0100, 3);
      add(0, 4'b0000, 0, 10,  0, 0, 0, 4'b0100, 0);
      add(0, 4'b0101, 0, 20,  0, 1, 0, 4'b0100, 3);
      add(0, 4'b0000, 0, 10,  0, 0, 0, 4'b0100, 0);
      add(0, 4'b0010, 0, 100, 1, 0, 0, 4'b0010, 3);
      add(0, 4'b0000, 0, 3,   0, 0, 0, 4'b0010, 3);
      add(0, 4'b0010, 0, 20,  0, 0, 0, 4'b0010, 3);
      add(0, 4'b0000, 0, 6,   0, 0, 0, 4'b0010, 0);
      add(0, 4'b0010, 0, 20,  1, 0, 0, 4'b0010, 3);
      add(0, 4'b0000, 0, 10,  0, 0, 0, 4'b0010, 0);
      add(0, 4'b0000, 1, 2,   0, 0, 0, 4'b0010, 0);
      add(0, 4'b0000, 0, 6,   0, 0, 0, 4'b0010, 0);
      add(0, 4'b0000, 1, 10,  0, 0, 1, 4'b0010, 0);
      add(0, 4'b0000, 0, 10,  0, 0, 0, 4'b0010, 0);
      add(0, 4'b1000, 0, 4,   0, 0, 0, 4'b0010, 1);
      add(1, 4'b1000, 0, 1,   0, 0, 0, 4'b0000, 0);
      add(0, 4'b0000, 0, 12,  0, 0, 0, 4'b0000, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst;
         botoes = tbl[i].b;
         iniciar_bruto = tbl[i].ib;
         seg_jog = 0; seg_err = 0; seg_ini = 0;
         repeat (tbl[i].n) tick();
         n_vec++;
         if (seg_jog != tbl[i].jog || seg_err != tbl[i].err || seg_ini != tbl[i].ini ||
             chaves !== tbl[i].ch || (tbl[i].st >= 0 && db_estado !== 4'(tbl[i].st))) begin
            n_err++;
            $display("FAIL seg%0d got jog=%0d err=%0d ini=%0d chaves=%b est=%0d, want jog=%0d err=%0d ini=%0d chaves=%b est=%0d",
                     i, seg_jog, seg_err, seg_ini, chaves, db_estado,
                     tbl[i].jog, tbl[i].err, tbl[i].ini, tbl[i].ch, tbl[i].st);
         end
      end

      // random segments: mostly idle/one-hot presses, some multi-button, rare resets
      for (int i = 0; i < 300; i++) begin
         int sel;
         reset = ($urandom_range(0, 40) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 5) botoes = 4'd0;
         else if (sel < 8) botoes = 4'(1 << $urandom_range(0, 3));
         else botoes = 4'($urandom_range(0, 15));
         iniciar_bruto = ($urandom_range(0, 2) == 0);
         repeat ($urandom_range(1, 12)) tick();
      end

      reset = 1'b0;
      botoes = 4'd0;
      iniciar_bruto = 1'b0;
      repeat (12) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
